// File: rtl/seq_alu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for seq_alu_muldiv. Holds the 4-bit ALU
//               op-code map, the FSM state encoding, and small op-class
//               helpers used by the top level.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    // The low codes keep the values of the original 3-bit ALU encoding.
    localparam alu_op_t OP_AND   = 4'b0000;
    localparam alu_op_t OP_OR    = 4'b0001;
    localparam alu_op_t OP_ADD   = 4'b0010;
    localparam alu_op_t OP_MFLO  = 4'b0011;
    localparam alu_op_t OP_MULT  = 4'b0100;
    localparam alu_op_t OP_MFHI  = 4'b0101;
    localparam alu_op_t OP_SUB   = 4'b0110;
    localparam alu_op_t OP_XOR   = 4'b0111;
    localparam alu_op_t OP_MULTU = 4'b1000;
    localparam alu_op_t OP_DIV   = 4'b1001;
    localparam alu_op_t OP_DIVU  = 4'b1010;

    typedef logic [1:0] alu_state_t;

    localparam alu_state_t IDLE = 2'd0;
    localparam alu_state_t CALC = 2'd1;
    localparam alu_state_t FIX  = 2'd2;
    localparam alu_state_t DONE = 2'd3;

    function automatic logic op_is_mul(input alu_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input alu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input alu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Iterative one-bit-per-cycle magnitude multiplier / restoring
//               divider. Operands are converted to magnitudes on load, WIDTH
//               step cycles run the shift-add or shift-subtract, and fix
//               applies the result signs in place.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               load           - capture a/b, is_div, is_signed; clear counter
//               step           - perform one iteration
//               fix            - apply signs to the accumulated result
//               is_div         - 1: divide, 0: multiply (sampled on load)
//               is_signed      - two's-complement operands (sampled on load)
//               a, b           - operands (multiplicand/multiplier or
//                                dividend/divisor)
//               hi, lo         - product {hi,lo} or remainder/quotient
//               last           - the current step is the final iteration
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   r_mag;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_hi;       // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo;       // multiplier bits / quotient bits
    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic               r_neg_lo;   // negate product (mul) or quotient (div)
    logic               r_neg_hi;   // negate remainder (div only)

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_sa    = is_signed & a[WIDTH-1];
    assign w_sb    = is_signed & b[WIDTH-1];
    assign w_mag_a = w_sa ? -a : a;
    assign w_mag_b = w_sb ? -b : b;

    // Multiply: add the multiplicand when the multiplier LSB is set; the carry
    // out lands in bit WIDTH and is shifted down into the high half.
    assign w_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mag : {WIDTH{1'b0}})};

    // Divide: shift the next dividend bit into the remainder and trial-subtract;
    // a clear borrow bit means the subtraction succeeded.
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_mag};

    assign w_prod_neg = -{r_hi, r_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
        end else if (load) begin
            r_cnt    <= '0;
            r_div    <= is_div;
            r_hi     <= '0;
            r_neg_lo <= w_sa ^ w_sb;
            if (is_div) begin
                r_mag    <= w_mag_b;
                r_lo     <= w_mag_a;
                r_neg_hi <= w_sa;
            end else begin
                r_mag    <= w_mag_a;
                r_lo     <= w_mag_b;
                r_neg_hi <= 1'b0;
            end
        end else if (step) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_div) begin
                if (!w_diff[WIDTH]) begin
                    r_hi <= w_diff[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_rem_sh[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end else if (fix) begin
            if (r_div) begin
                if (r_neg_lo) r_lo <= -r_lo;
                if (r_neg_hi) r_hi <= -r_hi;
            end else if (r_neg_lo) begin
                r_hi <= w_prod_neg[2*WIDTH-1:WIDTH];
                r_lo <= w_prod_neg[WIDTH-1:0];
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign last = (r_cnt == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_muldiv
// Description : Multi-cycle execute-stage ALU. Single-cycle logic/add/sub and
//               HI/LO moves, plus iterative signed/unsigned multiply and
//               divide through muldiv_core, behind a start/busy/done handshake.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               start         - request pulse, accepted only in IDLE
//               op, A, B      - operation and operands, latched on start
//               result        - registered result, held until the next done
//               done          - one-cycle completion pulse
//               busy          - a multiply/divide is iterating
//               zero          - live A == B comparison
//               div_by_zero   - last completed op was a divide by zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             zero,
    output logic             div_by_zero
);

    alu_state_t       r_state;
    alu_op_t          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_dbz;

    logic             w_accept;
    logic             w_live_md;
    logic             w_latched_md;
    logic             w_core_load;
    logic             w_core_step;
    logic             w_core_fix;
    logic             w_core_last;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic [WIDTH-1:0] w_alu;

    assign w_accept     = (r_state == IDLE) && start;
    assign w_live_md    = op_is_mul(op) || op_is_div(op);
    assign w_latched_md = op_is_mul(r_op) || op_is_div(r_op);
    assign w_core_load  = w_accept && w_live_md;
    assign w_core_step  = (r_state == CALC);
    assign w_core_fix   = (r_state == FIX);

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (w_core_load),
        .step      (w_core_step),
        .fix       (w_core_fix),
        .is_div    (op_is_div(op)),
        .is_signed (op_is_signed(op)),
        .a         (A),
        .b         (B),
        .hi        (w_core_hi),
        .lo        (w_core_lo),
        .last      (w_core_last)
    );

    // Single-cycle datapath works from the latched operands so it sees the
    // values present at start, and from HI/LO as they stand in DONE.
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_XOR:  w_alu = r_a ^ r_b;
            OP_MFLO: w_alu = r_lo;
            OP_MFHI: w_alu = r_hi;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_AND;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= A;
                        r_b     <= B;
                        r_state <= w_live_md ? CALC : DONE;
                    end
                end
                CALC: begin
                    if (w_core_last) r_state <= FIX;
                end
                FIX: begin
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    if (w_latched_md) begin
                        // Divide by zero bypasses the core: all-ones quotient,
                        // remainder is the untouched dividend.
                        if (op_is_div(r_op) && (r_b == '0)) begin
                            r_lo  <= '1;
                            r_hi  <= r_a;
                            r_dbz <= 1'b1;
                        end else begin
                            r_lo  <= w_core_lo;
                            r_hi  <= w_core_hi;
                            r_dbz <= 1'b0;
                        end
                    end else begin
                        r_result <= w_alu;
                        r_dbz    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign result      = r_result;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state == CALC) || (r_state == FIX);
    assign zero        = (A == B);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu_muldiv
// Description : Scoreboard testbench for seq_alu_muldiv (WIDTH=32). Each
//               issued operation pushes its expected result, div_by_zero flag
//               and completion cycle; a monitor pops and compares on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu_muldiv;

    localparam int W = 32;

    localparam logic [3:0] T_AND   = 4'b0000;
    localparam logic [3:0] T_OR    = 4'b0001;
    localparam logic [3:0] T_ADD   = 4'b0010;
    localparam logic [3:0] T_MFLO  = 4'b0011;
    localparam logic [3:0] T_MULT  = 4'b0100;
    localparam logic [3:0] T_MFHI  = 4'b0101;
    localparam logic [3:0] T_SUB   = 4'b0110;
    localparam logic [3:0] T_XOR   = 4'b0111;
    localparam logic [3:0] T_MULTU = 4'b1000;
    localparam logic [3:0] T_DIV   = 4'b1001;
    localparam logic [3:0] T_DIVU  = 4'b1010;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         zero;
    logic         div_by_zero;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [W-1:0] last_res = '0;

    seq_alu_muldiv #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .result      (result),
        .done        (done),
        .busy        (busy),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_dbz"}, {{(W-1){1'b0}}, div_by_zero}, {{(W-1){1'b0}}, e.dbz});
                chk({e.name, "_latency"}, W'(cyc), W'(e.cyc));
            end
        end
    end

    function automatic logic is_md(input logic [3:0] o);
        return (o == T_MULT) || (o == T_MULTU) || (o == T_DIV) || (o == T_DIVU);
    endfunction

    // Mul/div leave result untouched, so their expectation is the last result.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input logic exp_dbz, input string nm);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.name = nm;
        e.dbz  = exp_dbz;
        if (is_md(o)) begin
            e.res = last_res;
            e.cyc = cyc + W + 2;
        end else begin
            e.res    = exp_res;
            last_res = exp_res;
            e.cyc    = cyc + 1;
        end
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", nm);
        end
    endtask

    task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input logic exp_dbz, input string nm);
        issue(o, a, b, exp_res, exp_dbz, nm);
        wait_done(nm);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 4'b0000;
        A     = '0;
        B     = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_done",   {31'b0, done}, 32'h0);
        chk("reset_busy",   {31'b0, busy}, 32'h0);
        chk("reset_dbz",    {31'b0, div_by_zero}, 32'h0);
        rst = 1'b0;

        // Single-cycle ADD, busy must stay low, zero follows live inputs.
        issue(T_ADD, 32'd5, 32'd7, 32'd12, 1'b0, "add_5_7");
        chk("add_busy_low", {31'b0, busy}, 32'h0);
        chk("zero_5_7",     {31'b0, zero}, 32'h0);
        wait_done("add_5_7");
        A = 32'd9;
        B = 32'd9;
        #1;
        chk("zero_9_9", {31'b0, zero}, 32'h1);

        run(T_SUB, 32'd3,      32'd5,      32'hFFFF_FFFE, 1'b0, "sub_3_5");
        run(T_AND, 32'hF0F0,   32'hFF00,   32'h0000_F000, 1'b0, "and");
        run(T_OR,  32'hF0F0,   32'hFF00,   32'h0000_FFF0, 1'b0, "or");
        run(T_XOR, 32'hF0F0,   32'hFF00,   32'h0000_0FF0, 1'b0, "xor");
        run(4'b1111, 32'h1234, 32'h5678,   32'h0,         1'b0, "undef_op");

        // Signed multiply -3 * 7 = -21.
        issue(T_MULT, 32'hFFFF_FFFD, 32'd7, 32'h0, 1'b0, "mult_m3_7");
        repeat (5) @(negedge clk);
        chk("mult_busy_high", {31'b0, busy}, 32'h1);
        wait_done("mult_m3_7");
        run(T_MFLO, 32'h0, 32'h0, 32'hFFFF_FFEB, 1'b0, "mflo_mult");
        run(T_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, "mfhi_mult");

        // Unsigned max * max; a following ADD must leave HI/LO alone.
        run(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, "multu_max");
        chk("multu_busy_low", {31'b0, busy}, 32'h0);
        run(T_ADD,  32'd1, 32'd2, 32'd3,         1'b0, "add_after_multu");
        run(T_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, "mfhi_multu");
        run(T_MFLO, 32'h0, 32'h0, 32'h0000_0001, 1'b0, "mflo_multu");

        // Signed divide -7 / 2 = -3 rem -1.
        run(T_DIV,  32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, "div_m7_2");
        run(T_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFD, 1'b0, "mflo_div");
        run(T_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, "mfhi_div");

        // Most-negative / -1 wraps without trapping.
        run(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, "div_minneg");
        run(T_MFLO, 32'h0, 32'h0, 32'h8000_0000, 1'b0, "mflo_minneg");
        run(T_MFHI, 32'h0, 32'h0, 32'h0000_0000, 1'b0, "mfhi_minneg");

        // Unsigned divide 100 / 7 = 14 rem 2.
        run(T_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, "divu_100_7");
        run(T_MFLO, 32'h0, 32'h0, 32'd14, 1'b0, "mflo_divu");
        run(T_MFHI, 32'h0, 32'h0, 32'd2,  1'b0, "mfhi_divu");

        // Divide by zero sets the flag; the next op clears it.
        run(T_DIVU, 32'd10, 32'd0, 32'h0, 1'b1, "divu_by_zero");
        run(T_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, "mflo_dbz");
        run(T_MFHI, 32'h0, 32'h0, 32'h0000_000A, 1'b0, "mfhi_dbz");

        // Start pulsed during CALC must be ignored.
        issue(T_MULT, 32'd3, 32'd5, 32'h0, 1'b0, "mult_ignore_start");
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = T_ADD;
        A     = 32'd1;
        B     = 32'd1;
        #1;
        chk("zero_live_in_calc", {31'b0, zero}, 32'h1);
        @(negedge clk);
        start = 1'b0;
        wait_done("mult_ignore_start");
        run(T_MFLO, 32'h0, 32'h0, 32'd15, 1'b0, "mflo_ignore");

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1;
        op    = T_MULT;
        A     = 32'h1234_5678;
        B     = 32'h0BAD_CAFE;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("abort_busy_before", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_busy",   {31'b0, busy}, 32'h0);
        chk("abort_result", result, 32'h0);
        chk("abort_done",   {31'b0, done}, 32'h0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run(T_ADD,  32'd2, 32'd3, 32'd5, 1'b0, "add_after_rst");
        run(T_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, "mfhi_after_rst");
        run(T_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, "mflo_after_rst");

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending_expectations: got %0d outstanding expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu_muldiv.md
# seq_alu_muldiv

Parametrised multi-cycle ALU for the datapath execute stage. It performs single-cycle logic and add/sub operations, iterative signed and unsigned multiply and divide, and HI/LO register moves. A start/busy/done handshake lets the controller stall while a multiply or divide iterates. Its arithmetic encoding extends the existing 3-bit ALU operation code to a 4-bit code.

## Interface
- WIDTH, 32: operand, result, HI and LO width; must be even and ≥4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- op  input  4  operation, captured with start.
- A  input  WIDTH  operand A, captured with start.
- B  input  WIDTH  operand B, captured with start.
- result  output  WIDTH  registered result; holds until the next done.
- done  output  1  one-cycle pulse; result, HI and LO are valid.
- busy  output  1  high from the cycle after an accepted start until done.
- zero  output  1  combinational; 1 when A==B on the live inputs, independent of FSM.
- div_by_zero  output  1  registered; set with done of a DIV/DIVU with B=0, cleared with any other done.

## Operation
- Op codes:
  - Logic and add/sub: AND=0000, OR=0001, ADD=0010, SUB=0110, XOR=0111.
  - HI/LO moves: MFLO=0011 (result=LO), MFHI=0101 (result=HI).
  - Multiply: MULT=0100 (signed), MULTU=1000.
  - Divide: DIV=1001 (signed), DIVU=1010.
  - Other codes: executed as a single-cycle op giving result=0.
- Add and subtract are modulo 2^WIDTH; no overflow flag.
- Multiply: {HI,LO} = full 2*WIDTH-bit product; result is unchanged.
  - Method: operands are converted to magnitudes, a shift-add runs one bit per cycle, and the sign is applied in FIX.
- Divide: LO=quotient and HI=remainder, truncating toward zero; the remainder takes the dividend's sign.
  - Method: restoring division on magnitudes, one bit per cycle.
- DIV of most-negative by -1: LO=most-negative, HI=0 (no trap).
- Divide by zero: LO=all ones, HI=A, div_by_zero=1.
- HI/LO are written only at completion of a mul/div; other ops do not touch them.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE→DONE: start with a single-cycle op.
  - IDLE→CALC: start with a mul/div op.
  - CALC→FIX: after WIDTH iterations.
  - FIX→DONE: always.
  - DONE→IDLE: always.
- start while busy=1, or in DONE, is ignored (not queued).

## Timing
- Reset values: result=0, done=0, busy=0, div_by_zero=0, HI=0, LO=0, FSM=IDLE, iteration counter=0.
- Reset mid-operation aborts immediately (asynchronous): HI/LO return to 0 and no done is issued.
- Single-cycle op: start sampled at edge N; done=1 and result valid after edge N+1; busy stays 0.
- Mul/div: start sampled at edge N.
  - busy=1 after edge N+1 through FIX.
  - done=1 after edge N+WIDTH+2 (34 cycles at WIDTH=32).
  - HI/LO updated on that same edge.
  - busy=0 in DONE.
- New start is accepted in IDLE only, i.e. the cycle after done at the earliest.
- MFHI/MFLO issued right after a mul/div done read the new HI/LO.
- Operands and op are latched at start; input changes during CALC have no effect. zero still tracks the live A and B.

## Structure
- Package alu_pkg:
  - op-code localparams/enum alu_op_t.
  - state enum alu_state_t {IDLE, CALC, FIX, DONE}.
- Sub-module muldiv_core(WIDTH):
  - holds the magnitude registers, shift logic and iteration counter.
  - has its own load/step/fix controls driven by the top FSM and returns {hi,lo}.
- The top level owns the FSM, HI/LO, result, done/busy and the zero comparator.

## Test plan
- ADD A=5, B=7: done one cycle after start, result=12, busy never high; zero=0. Then A=B=9 gives zero=1.
- MULT A=FFFFFFFD (-3), B=7: done 34 cycles after start, HI=FFFFFFFF, LO=FFFFFFEB. Following MFLO gives result=FFFFFFEB; MFHI gives FFFFFFFF.
- MULTU FFFFFFFF×FFFFFFFF: HI=FFFFFFFE, LO=00000001. A subsequent ADD leaves HI/LO unchanged.
- DIV A=FFFFFFF9 (-7), B=2: LO=FFFFFFFD, HI=FFFFFFFF.
  - DIV 80000000 / FFFFFFFF: LO=80000000, HI=0.
  - DIVU A=10, B=0: LO=FFFFFFFF, HI=0000000A, div_by_zero=1.
- Start pulsed during CALC with op=ADD: ignored, single done at cycle 34 with mul result.
- rst raised at cycle 10 of a MULT: busy, HI, LO immediately 0, no done. A fresh ADD afterwards completes normally.
